// File: rtl/noc_mesh_router_if.sv
// Flit-level valid/ready bundle for one noc_mesh_router: five input ports and
// five output ports, each port packed FLIT_W bits wide at [p*FLIT_W +: FLIT_W].
interface noc_mesh_router_if #(
  parameter int FLIT_W = 36
);
  logic [5*FLIT_W-1:0] in_flit;
  logic [4:0]          in_valid;
  logic [4:0]          in_ready;
  logic [5*FLIT_W-1:0] out_flit;
  logic [4:0]          out_valid;
  logic [4:0]          out_ready;

  modport slave (
    input  in_flit, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );

  modport master (
    output in_flit, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );
endinterface

// File: rtl/noc_mesh_router.sv
// 5-port mesh router: per-input FIFOs, XY/YX dimension-ordered routing, round-robin
// output arbitration into registered outputs. Define NOC_ROUTER_STATS_EN for counters.
module noc_mesh_router #(
  parameter int SIZE_X     = 4,
  parameter int SIZE_Y     = 4,
  parameter int POS_X      = 0,
  parameter int POS_Y      = 0,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ROUTING    = 0
) (
  input  logic clk,
  input  logic rst_n,
  noc_mesh_router_if.slave bus
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [5*16-1:0] fwd_cnt,
  output logic [15:0]     drop_cnt
`endif
);
  localparam int NP     = 5;
  localparam int XW     = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int YW     = (SIZE_Y > 1) ? $clog2(SIZE_Y) : 1;
  localparam int FLIT_W = YW + XW + DATA_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_S = 3'd3;
  localparam logic [2:0] P_W = 3'd4;

  logic [FLIT_W-1:0] mem_q      [NP][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q   [NP];
  logic [AW-1:0]     wr_ptr_d   [NP];
  logic [AW-1:0]     rd_ptr_q   [NP];
  logic [AW-1:0]     rd_ptr_d   [NP];
  logic [CW-1:0]     cnt_q      [NP];
  logic [CW-1:0]     cnt_d      [NP];
  logic [2:0]        ptr_q      [NP];
  logic [2:0]        ptr_d      [NP];
  logic [FLIT_W-1:0] out_flit_q [NP];
  logic [FLIT_W-1:0] out_flit_d [NP];
  logic [NP-1:0]     out_valid_q, out_valid_d;
  logic [NP-1:0]     empty, full, push, drop, gnt_pop, rd_en;
  logic [FLIT_W-1:0] head  [NP];
  logic [2:0]        route [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      empty[p] = (cnt_q[p] == '0);
      full[p]  = (cnt_q[p] == CW'(FIFO_DEPTH));
      push[p]  = bus.in_valid[p] && !full[p];
    end
  end

  // Head-of-line route decode; unreachable or out-of-mesh destinations are dropped.
  always_comb begin
    int   dx;
    int   dy;
    logic bad;
    for (int p = 0; p < NP; p++) begin
      head[p] = mem_q[p][rd_ptr_q[p]];
      dx      = int'(head[p][DATA_W +: XW]);
      dy      = int'(head[p][DATA_W+XW +: YW]);
      if (ROUTING == 0) begin
        if      (dx > POS_X) route[p] = P_E;
        else if (dx < POS_X) route[p] = P_W;
        else if (dy > POS_Y) route[p] = P_S;
        else if (dy < POS_Y) route[p] = P_N;
        else                 route[p] = P_L;
      end else begin
        if      (dy > POS_Y) route[p] = P_S;
        else if (dy < POS_Y) route[p] = P_N;
        else if (dx > POS_X) route[p] = P_E;
        else if (dx < POS_X) route[p] = P_W;
        else                 route[p] = P_L;
      end
      bad = (dx >= SIZE_X) || (dy >= SIZE_Y) ||
            (route[p] == P_N && POS_Y == 0) || (route[p] == P_S && POS_Y == SIZE_Y-1) ||
            (route[p] == P_W && POS_X == 0) || (route[p] == P_E && POS_X == SIZE_X-1);
      drop[p] = !empty[p] && bad;
    end
  end

  // Round-robin per output, searching upward from ptr; a slot is free when empty or draining.
  always_comb begin
    logic       found;
    logic [2:0] win;
    int         idx;
    gnt_pop     = '0;
    out_valid_d = out_valid_q;
    for (int o = 0; o < NP; o++) begin
      ptr_d[o]      = ptr_q[o];
      out_flit_d[o] = out_flit_q[o];
    end
    for (int o = 0; o < NP; o++) begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NP; k++) begin
        idx = (int'(ptr_q[o]) + k) % NP;
        if (!found && !empty[idx] && !drop[idx] && route[idx] == 3'(o)) begin
          found = 1'b1;
          win   = 3'(idx);
        end
      end
      if (!out_valid_q[o] || bus.out_ready[o]) begin
        out_valid_d[o] = found;
        if (found) begin
          out_flit_d[o] = head[win];
          gnt_pop[win]  = 1'b1;
          ptr_d[o]      = (win == P_W) ? P_L : win + 3'd1;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rd_en[p]    = gnt_pop[p] || drop[p];
      wr_ptr_d[p] = wr_ptr_q[p] + AW'(push[p]);
      rd_ptr_d[p] = rd_ptr_q[p] + AW'(rd_en[p]);
      cnt_d[p]    = cnt_q[p] + CW'(push[p]) - CW'(rd_en[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p]   <= '0;
        rd_ptr_q[p]   <= '0;
        cnt_q[p]      <= '0;
        ptr_q[p]      <= '0;
        out_flit_q[p] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p]   <= wr_ptr_d[p];
        rd_ptr_q[p]   <= rd_ptr_d[p];
        cnt_q[p]      <= cnt_d[p];
        ptr_q[p]      <= ptr_d[p];
        out_flit_q[p] <= out_flit_d[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= bus.in_flit[p*FLIT_W +: FLIT_W];
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) bus.out_flit[o*FLIT_W +: FLIT_W] = out_flit_q[o];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = ~full;

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] fwd_cnt_q [NP];
  logic [15:0] fwd_cnt_d [NP];
  logic [15:0] drop_cnt_q, drop_cnt_d;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    for (int o = 0; o < NP; o++)
      fwd_cnt_d[o] = sat_add16(fwd_cnt_q[o], {2'b00, out_valid_q[o] && bus.out_ready[o]});
    drop_cnt_d = sat_add16(drop_cnt_q, 3'($countones(drop)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      for (int o = 0; o < NP; o++) fwd_cnt_q[o] <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      for (int o = 0; o < NP; o++) fwd_cnt_q[o] <= fwd_cnt_d[o];
    end
  end

  always_comb begin
    for (int o = 0; o < NP; o++) fwd_cnt[o*16 +: 16] = fwd_cnt_q[o];
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_noc_mesh_router.sv
// Scoreboard bench for noc_mesh_router: main router at (1,1) of a 4x4 XY mesh, a YX
// twin at the same spot, and a 3x3 router at (0,0) for invalid-destination drops.
module tb_noc_mesh_router;
  localparam int FW = 36;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_mesh_router_if #(.FLIT_W(FW)) ifa ();
  noc_mesh_router_if #(.FLIT_W(FW)) ifb ();
  noc_mesh_router_if #(.FLIT_W(FW)) ifc ();

`ifdef NOC_ROUTER_STATS_EN
  logic [79:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] drop_a, drop_b, drop_c;
`endif

  noc_mesh_router #(.SIZE_X(4), .SIZE_Y(4), .POS_X(1), .POS_Y(1), .DATA_W(32),
                    .FIFO_DEPTH(4), .ROUTING(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
`ifdef NOC_ROUTER_STATS_EN
    , .fwd_cnt(fwd_a), .drop_cnt(drop_a)
`endif
  );

  noc_mesh_router #(.SIZE_X(4), .SIZE_Y(4), .POS_X(1), .POS_Y(1), .DATA_W(32),
                    .FIFO_DEPTH(4), .ROUTING(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
`ifdef NOC_ROUTER_STATS_EN
    , .fwd_cnt(fwd_b), .drop_cnt(drop_b)
`endif
  );

  noc_mesh_router #(.SIZE_X(3), .SIZE_Y(3), .POS_X(0), .POS_Y(0), .DATA_W(32),
                    .FIFO_DEPTH(4), .ROUTING(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
`ifdef NOC_ROUTER_STATS_EN
    , .fwd_cnt(fwd_c), .drop_cnt(drop_c)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] stim_q [5][$];
  logic [FW-1:0] exp_q  [5][$];
  logic [4:0]    acc;
  logic [4:0]    rdy_cfg;
  logic          rand_rdy;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input int dx, input int dy, input logic [31:0] pl);
    return {2'(dy), 2'(dx), pl};
  endfunction

  // Reference dimension-ordered routing; -1 means the flit is dropped.
  function automatic int route_model(input int px, input int py, input int sx, input int sy,
                                     input int yx, input int dx, input int dy);
    int ddx = dx - px;
    int ddy = dy - py;
    int dir = 0;
    if (dx >= sx || dy >= sy) return -1;
    if (yx != 0) begin
      if (ddy != 0)      dir = (ddy > 0) ? 3 : 1;
      else if (ddx != 0) dir = (ddx > 0) ? 2 : 4;
    end else begin
      if (ddx != 0)      dir = (ddx > 0) ? 2 : 4;
      else if (ddy != 0) dir = (ddy > 0) ? 3 : 1;
    end
    if ((dir == 1 && py == 0) || (dir == 3 && py == sy-1) ||
        (dir == 4 && px == 0) || (dir == 2 && px == sx-1)) return -1;
    return dir;
  endfunction

  task automatic inject(input int p, input int dx, input int dy, input logic [31:0] pl);
    logic [FW-1:0] f;
    int o;
    f = mk(dx, dy, pl);
    stim_q[p].push_back(f);
    o = route_model(1, 1, 4, 4, 0, dx, dy);
    if (o >= 0) exp_q[o].push_back(f);
  endtask

  // One cycle of router A: compare outputs that transfer at the coming edge, then drive inputs.
  task automatic tick();
    logic [FW-1:0] e;
    @(negedge clk);
    ifa.out_ready = rand_rdy ? 5'($urandom) : rdy_cfg;
    for (int o = 0; o < 5; o++) begin
      if (ifa.out_valid[o] && ifa.out_ready[o]) begin
        if (exp_q[o].size() == 0) begin
          check_val($sformatf("spurious_out%0d", o), 64'(ifa.out_valid[o]), 64'd0);
        end else begin
          e = exp_q[o].pop_front();
          check_val($sformatf("flit_out%0d", o), 64'(ifa.out_flit[o*FW +: FW]), 64'(e));
        end
      end
    end
    for (int p = 0; p < 5; p++) begin
      if (acc[p]) void'(stim_q[p].pop_front());
      if (stim_q[p].size() > 0) begin
        ifa.in_valid[p]            = 1'b1;
        ifa.in_flit[p*FW +: FW]    = stim_q[p][0];
      end else begin
        ifa.in_valid[p]            = 1'b0;
      end
      acc[p] = ifa.in_valid[p] && ifa.in_ready[p];
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < 5; p++) n += stim_q[p].size() + exp_q[p].size();
    return n;
  endfunction

  task automatic drain(input int max_cyc);
    int n = 0;
    while (pending() > 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check_val("drain_timeout", 64'(pending()), 64'd0);
  endtask

  task automatic clear_queues();
    for (int p = 0; p < 5; p++) begin
      stim_q[p].delete();
      exp_q[p].delete();
    end
    acc          = '0;
    ifa.in_valid = '0;
  endtask

  task automatic do_reset();
    clear_queues();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifa.in_flit = '0; ifa.in_valid = '0; ifa.out_ready = '0;
    ifb.in_flit = '0; ifb.in_valid = '0; ifb.out_ready = 5'h1F;
    ifc.in_flit = '0; ifc.in_valid = '0; ifc.out_ready = 5'h1F;
    rdy_cfg  = 5'h1F;
    rand_rdy = 1'b0;
    acc      = '0;

    do_reset();
    check_val("rst_in_ready", 64'(ifa.in_ready), 64'h1F);
    check_val("rst_out_valid", 64'(ifa.out_valid), 64'h0);

    // Local -> (3,1): East, visible two edges after it is presented
    inject(0, 3, 1, 32'hA5);
    tick();
    tick();
    check_val("lat_edge1_ov", 64'(ifa.out_valid), 64'h0);
    tick();
    check_val("lat_edge2_ov", 64'(ifa.out_valid), 64'b00100);
    drain(20);

    // XY router sends (2,3) East
    inject(0, 2, 3, 32'h5A5A);
    drain(20);

    // YX router sends (2,3) South
    ifb.in_flit[0 +: FW] = mk(2, 3, 32'h77);
    ifb.in_valid         = 5'b00001;
    tick();
    ifb.in_valid         = 5'b00000;
    check_val("yx_edge1_ov", 64'(ifb.out_valid), 64'h0);
    tick();
    check_val("yx_ov", 64'(ifb.out_valid), 64'b01000);
    check_val("yx_flit", 64'(ifb.out_flit[3*FW +: FW]), 64'(mk(2, 3, 32'h77)));

    // 3x3 router at (0,0): North (0,0) delivered locally, Local (3,3) dropped
    ifc.in_flit[1*FW +: FW] = mk(0, 0, 32'h11);
    ifc.in_flit[0*FW +: FW] = mk(3, 3, 32'h22);
    ifc.in_valid            = 5'b00011;
    tick();
    ifc.in_valid            = 5'b00000;
    tick();
    check_val("edge_ov", 64'(ifc.out_valid), 64'b00001);
    check_val("edge_flit", 64'(ifc.out_flit[0 +: FW]), 64'(mk(0, 0, 32'h11)));
    tick();
    check_val("edge_ov_after", 64'(ifc.out_valid), 64'h0);
    check_val("edge_in_ready", 64'(ifc.in_ready), 64'h1F);
`ifdef NOC_ROUTER_STATS_EN
    check_val("edge_drop_cnt", 64'(drop_c), 64'd1);
    check_val("edge_fwd_local", 64'(fwd_c[15:0]), 64'd1);
    check_val("yx_fwd_south", 64'(fwd_b[3*16 +: 16]), 64'd1);
`endif

    // Round robin on Local output: expected grant order Local, North, West
    do_reset();
    for (int r = 0; r < 3; r++) begin
      inject(0, 1, 1, 32'h000 + r);
      inject(1, 1, 1, 32'h100 + r);
      inject(4, 1, 1, 32'h400 + r);
    end
    drain(40);

    // Full throughput: 8 back-to-back flits leave on consecutive cycles
    for (int i = 0; i < 8; i++) inject(0, 3, 1, 32'h200 + i);
    n = 0;
    while (exp_q[2].size() > 0 && n < 50) begin
      tick();
      n++;
    end
    check_val("thru_cycles", 64'(n), 64'd10);
    drain(20);

    // Backpressure: East stalled, 5 flits fill out register plus FIFO
    rdy_cfg = 5'b11011;
    for (int i = 0; i < 5; i++) inject(0, 3, 1, 32'h100 + i);
    repeat (8) tick();
    check_val("bp_all_accepted", 64'(stim_q[0].size()), 64'd0);
    check_val("bp_in_ready_low", 64'(ifa.in_ready[0]), 64'd0);
    check_val("bp_ov_held", 64'(ifa.out_valid[2]), 64'd1);
    check_val("bp_flit_held", 64'(ifa.out_flit[2*FW +: FW]), 64'(mk(3, 1, 32'h100)));
    rdy_cfg = 5'h1F;
    tick();
    tick();
    check_val("bp_in_ready_back", 64'(ifa.in_ready[0]), 64'd1);
    drain(30);

    // Mixed traffic, one source per output, random downstream readiness
    rand_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      inject(1, 1, 3, $urandom);
      inject(3, 1, 0, $urandom);
      inject(2, 0, 1, $urandom);
      inject(4, 2, 1, $urandom);
      inject(0, 1, 1, $urandom);
    end
    drain(300);
    rand_rdy = 1'b0;
`ifdef NOC_ROUTER_STATS_EN
    check_val("a_drop_cnt", 64'(drop_a), 64'd0);
`endif

    // Reset with buffered flits and a held output discards everything
    rdy_cfg = 5'h00;
    for (int i = 0; i < 4; i++) inject(0, 3, 1, 32'h300 + i);
    repeat (7) tick();
    check_val("rst_pre_ov", 64'(ifa.out_valid), 64'b00100);
    clear_queues();
    rst_n = 1'b0;
    tick();
    check_val("rst_mid_ov", 64'(ifa.out_valid), 64'h0);
    check_val("rst_mid_in_ready", 64'(ifa.in_ready), 64'h1F);
    rst_n   = 1'b1;
    rdy_cfg = 5'h1F;
    repeat (6) tick();
    check_val("rst_no_stale", 64'(ifa.out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
